// File: rtl/drop_controller.sv
// Board owner and move sequencer for the 7x6 four-in-a-row game: validates a put, drops the
// piece, then walks the four line directions around it. Optional draw detection: DRAW_DETECT_EN.
module drop_controller #(
    parameter int unsigned COLS    = 7,
    parameter int unsigned ROWS    = 6,
    parameter int unsigned WIN_LEN = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       put_i,
    input  logic [2:0] col_i,
    input  logic       turn_i,
    output logic       invalid_move_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       win_o,
    output logic       winner_o,
    output logic       draw_o,
    input  logic [2:0] rd_row_i,
    input  logic [2:0] rd_col_i,
    output logic [1:0] rd_cell_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_FIN   = 2'd2
    } state_t;

    localparam logic [2:0]        COLS_U = 3'(COLS);
    localparam logic [2:0]        ROWS_U = 3'(ROWS);
    localparam logic [2:0]        WIN_U  = 3'(WIN_LEN);
    localparam logic signed [4:0] COLS_S = 5'(COLS);
    localparam logic signed [4:0] ROWS_S = 5'(ROWS);

    state_t     state_q, state_d;
    logic [2:0] row_q, row_d;
    logic [2:0] colp_q, colp_d;
    logic       turn_q, turn_d;
    logic [1:0] dir_q, dir_d;
    logic       side_q, side_d;
    logic [2:0] step_q, step_d;
    logic [2:0] count_q, count_d;
    logic       win_q, win_d;
    logic       winner_q, winner_d;

    logic [1:0] cell_q [ROWS][COLS];
    logic [2:0] height_q [COLS];

    logic       col_ok;
    logic [2:0] cur_height;
    logic [2:0] height_inc;
    logic       busy;
    logic       accept;
    logic       place_en;
    logic       end_side;

    logic signed [4:0] off;
    logic signed [4:0] base_r, base_c;
    logic signed [4:0] nr, nc;
    logic              in_bounds;
    logic [2:0]        nr_idx, nc_idx;
    logic [1:0]        nbr_cell;
    logic              match;

    // Handshake: put_i is a one-cycle request sampled with col_i/turn_i; it is accepted in that
    // same cycle exactly when invalid_move_o is low, otherwise it is dropped with no state change.
    assign col_ok         = (col_i < COLS_U);
    assign cur_height     = col_ok ? height_q[col_i] : ROWS_U;
    assign height_inc     = (cur_height >= ROWS_U) ? ROWS_U : cur_height + 3'd1;
    assign busy           = (state_q != S_IDLE);
    assign invalid_move_o = put_i & (busy | ~col_ok | (cur_height == ROWS_U) | win_q | draw_o);
    assign accept         = put_i & ~invalid_move_o;

    assign busy_o    = busy;
    assign done_o    = (state_q == S_FIN);
    assign win_o     = win_q;
    assign winner_o  = winner_q;
    assign state_o   = state_q;
    assign rd_cell_o = ((rd_row_i < ROWS_U) && (rd_col_i < COLS_U)) ?
                       cell_q[rd_row_i][rd_col_i] : 2'b00;

    // Neighbour under test: latched position plus step along the current direction and side.
    always_comb begin
        off    = side_q ? -$signed({2'b00, step_q}) : $signed({2'b00, step_q});
        base_r = $signed({2'b00, row_q});
        base_c = $signed({2'b00, colp_q});
        nr     = base_r;
        nc     = base_c;
        case (dir_q)
            2'd0: begin
                nr = base_r;
                nc = base_c + off;
            end
            2'd1: begin
                nr = base_r + off;
                nc = base_c;
            end
            2'd2: begin
                nr = base_r + off;
                nc = base_c + off;
            end
            default: begin
                nr = base_r + off;
                nc = base_c - off;
            end
        endcase
        in_bounds = (nr >= 5'sd0) && (nr < ROWS_S) && (nc >= 5'sd0) && (nc < COLS_S);
        nr_idx    = in_bounds ? nr[2:0] : 3'd0;
        nc_idx    = in_bounds ? nc[2:0] : 3'd0;
        nbr_cell  = in_bounds ? cell_q[nr_idx][nc_idx] : 2'b00;
        match     = in_bounds && (nbr_cell == {turn_q, ~turn_q});
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        colp_d   = colp_q;
        turn_d   = turn_q;
        dir_d    = dir_q;
        side_d   = side_q;
        step_d   = step_q;
        count_d  = count_q;
        win_d    = win_q;
        winner_d = winner_q;
        place_en = 1'b0;
        end_side = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    place_en = 1'b1;
                    row_d    = cur_height;
                    colp_d   = col_i;
                    turn_d   = turn_i;
                    dir_d    = 2'd0;
                    side_d   = 1'b0;
                    step_d   = 3'd1;
                    count_d  = 3'd1;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (match) begin
                    if (count_q + 3'd1 == WIN_U) begin
                        win_d    = 1'b1;
                        winner_d = turn_q;
                        state_d  = S_FIN;
                    end else begin
                        count_d = count_q + 3'd1;
                        step_d  = step_q + 3'd1;
                        if (step_q + 3'd1 == WIN_U) begin
                            end_side = 1'b1;
                        end
                    end
                end else begin
                    end_side = 1'b1;
                end
                if (end_side) begin
                    step_d = 3'd1;
                    if (!side_q) begin
                        side_d = 1'b1;
                    end else if (dir_q == 2'd3) begin
                        state_d = S_FIN;
                    end else begin
                        dir_d   = dir_q + 2'd1;
                        side_d  = 1'b0;
                        count_d = 3'd1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            colp_q   <= '0;
            turn_q   <= 1'b0;
            dir_q    <= '0;
            side_q   <= 1'b0;
            step_q   <= '0;
            count_q  <= '0;
            win_q    <= 1'b0;
            winner_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            colp_q   <= colp_d;
            turn_q   <= turn_d;
            dir_q    <= dir_d;
            side_q   <= side_d;
            step_q   <= step_d;
            count_q  <= count_d;
            win_q    <= win_d;
            winner_q <= winner_d;
        end
    end

    // Piece encoding is turn+1: red 01, yellow 10.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    cell_q[r][c] <= 2'b00;
                end
            end
            for (int unsigned c = 0; c < COLS; c++) begin
                height_q[c] <= 3'd0;
            end
        end else if (place_en) begin
            cell_q[cur_height][col_i] <= {turn_i, ~turn_i};
            height_q[col_i]           <= height_inc;
        end
    end

`ifdef DRAW_DETECT_EN
    localparam logic [5:0] CELLS = 6'(ROWS * COLS);

    logic [5:0] moves_q, moves_d;
    logic       draw_q, draw_d;

    always_comb begin
        moves_d = moves_q;
        draw_d  = draw_q;
        if (place_en && (moves_q != CELLS)) begin
            moves_d = moves_q + 6'd1;
        end
        if ((state_q == S_FIN) && !win_q && (moves_q == CELLS)) begin
            draw_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            moves_q <= '0;
            draw_q  <= 1'b0;
        end else begin
            moves_q <= moves_d;
            draw_q  <= draw_d;
        end
    end

    assign draw_o = draw_q;
`else
    assign draw_o = 1'b0;
`endif

endmodule
